pc_seq_ctrl: RTL and testbench

//  Next-PC sequencer for the fetch stage: drives write-enable and next value of the PC register.

---
 rtl/pc_seq_ctrl.sv | 127 ++++++++++++
 tb/tb_pc_seq_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pc_seq_ctrl.sv
// Next-PC sequencer: picks the fetch PC (seq / branch / exception / rfi) and holds SRR0.
// pc_wr and npc are combinational, exc_ack is one cycle later; redirects seen under stall wait in PEND.
// Stall blocks all PC writes; the first redirect and the first exception are kept until release.
module pc_seq_ctrl #(
   parameter int                  PC_WIDTH    = 32,
   parameter logic [PC_WIDTH-1:0] RESET_ADDR  = 32'h0000_3000,
   parameter logic [PC_WIDTH-1:0] EXC_BASE    = 32'h0000_0100,
   parameter int                  BOOT_CYCLES = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                stall,
   input  logic [PC_WIDTH-1:0] pc,
   input  logic                br_taken,
   input  logic [PC_WIDTH-1:0] br_target,
   input  logic                rfi,
   input  logic                exc_req,
   input  logic [3:0]          exc_vec,
   output logic                pc_wr,
   output logic [PC_WIDTH-1:0] npc,
   output logic [PC_WIDTH-1:0] srr0,
   output logic                exc_ack,
   output logic                busy
);

   typedef enum logic [1:0] {BOOT, RUN, PEND} state_t;

   state_t              state;
   logic [3:0]          boot_cnt;
   logic [PC_WIDTH-1:0] pend_addr;
   logic                pend_exc;

   logic [PC_WIDTH-1:0] exc_tgt;
   logic [PC_WIDTH-1:0] br_tgt;
   logic [PC_WIDTH-1:0] seq_tgt;
   logic [PC_WIDTH-1:0] req_tgt;
   logic                req_any;
   logic                exc_new;

   always_comb begin
      exc_tgt = EXC_BASE + (PC_WIDTH'(exc_vec) << 8);
      br_tgt  = br_target & ~PC_WIDTH'(3);
      seq_tgt = pc + PC_WIDTH'(4);
      req_any = exc_req | rfi | br_taken;
      exc_new = exc_req & ~pend_exc;
      if (exc_req)
         req_tgt = exc_tgt;
      else if (rfi)
         req_tgt = srr0;
      else if (br_taken)
         req_tgt = br_tgt;
      else
         req_tgt = seq_tgt;
   end

   always_comb begin
      pc_wr = 1'b0;
      npc   = seq_tgt;
      case (state)
         BOOT: npc = RESET_ADDR;
         RUN: begin
            pc_wr = ~stall;
            if (!stall)
               npc = req_tgt;
         end
         PEND: begin
            pc_wr = ~stall;
            npc   = exc_new ? exc_tgt : pend_addr;
         end
         default: begin
            pc_wr = 1'b0;
            npc   = RESET_ADDR;
         end
      endcase
   end

   assign busy = (state != RUN);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= BOOT;
         boot_cnt  <= '0;
         pend_addr <= '0;
         pend_exc  <= 1'b0;
         srr0      <= '0;
         exc_ack   <= 1'b0;
      end else begin
         exc_ack <= 1'b0;
         case (state)
            BOOT: begin
               boot_cnt <= boot_cnt + 4'd1;
               if (boot_cnt == 4'(BOOT_CYCLES - 1))
                  state <= RUN;
            end
            RUN: begin
               if (exc_req) begin
                  srr0    <= pc;
                  exc_ack <= 1'b1;
               end
               if (stall && req_any) begin
                  pend_addr <= req_tgt;
                  pend_exc  <= exc_req;
                  state     <= PEND;
               end
            end
            PEND: begin
               // Only a first exception may replace the held redirect; rfi/branch are dropped.
               if (exc_new) begin
                  srr0    <= pc;
                  exc_ack <= 1'b1;
               end
               if (stall) begin
                  if (exc_new) begin
                     pend_addr <= exc_tgt;
                     pend_exc  <= 1'b1;
                  end
               end else begin
                  pend_exc <= 1'b0;
                  state    <= RUN;
               end
            end
            default: state <= BOOT;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Scoreboard bench for pc_seq_ctrl: directed cases followed by random traffic.
module tb_pc_seq_ctrl;
   localparam logic [31:0] RA = 32'h0000_3000;
   localparam logic [31:0] EB = 32'h0000_0100;
   localparam int          BC = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic [31:0] pc = RA;
   logic        br_taken = 1'b0;
   logic [31:0] br_target = '0;
   logic        rfi = 1'b0;
   logic        exc_req = 1'b0;
   logic [3:0]  exc_vec = '0;
   logic        pc_wr;
   logic [31:0] npc;
   logic [31:0] srr0;
   logic        exc_ack;
   logic        busy;

   pc_seq_ctrl #(.PC_WIDTH(32), .RESET_ADDR(RA), .EXC_BASE(EB), .BOOT_CYCLES(BC)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .pc(pc),
      .br_taken(br_taken), .br_target(br_target), .rfi(rfi),
      .exc_req(exc_req), .exc_vec(exc_vec),
      .pc_wr(pc_wr), .npc(npc), .srr0(srr0), .exc_ack(exc_ack), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          chk;
      bit          wr;
      bit          npc_chk;
      logic [31:0] npc;
      bit          busy;
      bit          ack;
      logic [31:0] srr0;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;

   // Reference model: boot countdown, an optional held redirect, saved return PC, and the plant PC.
   bit          m_known = 1'b0;
   int          m_boot = 0;
   bit          m_pv = 1'b0;
   bit          m_px = 1'b0;
   logic [31:0] m_pa = '0;
   logic [31:0] m_srr0 = '0;
   bit          m_ack = 1'b0;
   logic [31:0] m_pc = RA;

   task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", n, act, req, $time);
      end
   endtask

   task automatic cyc(input bit r, input bit s, input bit b, input logic [31:0] bt,
                      input bit f, input bit e, input logic [3:0] v);
      exp_t        x;
      logic [31:0] et, bt2, pri, old_pc;
      bit          enew;
      @(posedge clk);
      #1;
      rst_n = r; stall = s; br_taken = b; br_target = bt;
      rfi = f; exc_req = e; exc_vec = v; pc = m_pc;
      old_pc = m_pc;
      et  = EB + 32'(v) * 32'd256;
      bt2 = (bt / 4) * 4;
      pri = e ? et : (f ? m_srr0 : (b ? bt2 : m_pc + 32'd4));
      enew = e && !m_px;
      x.chk     = m_known;
      x.busy    = (m_boot > 0) || m_pv;
      x.wr      = (m_boot == 0) && !s;
      x.npc     = (m_boot > 0) ? RA : (m_pv ? (enew ? et : m_pa) : pri);
      x.npc_chk = (m_boot > 0) || x.wr;
      x.ack     = m_ack;
      x.srr0    = m_srr0;
      q.push_back(x);
      if (x.wr) m_pc = x.npc;
      if (!r) begin
         m_known = 1'b1; m_boot = BC; m_pv = 1'b0; m_px = 1'b0;
         m_pa = '0; m_srr0 = '0; m_ack = 1'b0; m_pc = RA;
      end else begin
         m_ack = 1'b0;
         if (m_boot > 0) begin
            m_boot--;
         end else if (!m_pv) begin
            if (e) begin m_srr0 = old_pc; m_ack = 1'b1; end
            if (s && (e || f || b)) begin m_pv = 1'b1; m_pa = pri; m_px = e; end
         end else begin
            if (enew) begin m_srr0 = old_pc; m_ack = 1'b1; end
            if (s) begin
               if (enew) begin m_pa = et; m_px = 1'b1; end
            end else begin
               m_pv = 1'b0; m_px = 1'b0;
            end
         end
      end
   endtask

   task automatic idle(input bit s);
      cyc(1'b1, s, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0);
   endtask

   initial begin : monitor
      exp_t x;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            x = q.pop_front();
            if (x.chk) begin
               cmp("pc_wr", 32'(pc_wr), 32'(x.wr));
               cmp("busy", 32'(busy), 32'(x.busy));
               cmp("exc_ack", 32'(exc_ack), 32'(x.ack));
               cmp("srr0", srr0, x.srr0);
               if (x.npc_chk) cmp("npc", npc, x.npc);
            end
         end
      end
   end

   initial begin : driver
      bit r, s, b, f, e;
      // reset and boot
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0);
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0);
      repeat (4) idle(1'b0);
      // wrap of sequential fetch
      m_pc = 32'hFFFF_FFFC; idle(1'b0); idle(1'b0);
      // branch with LSBs masked
      m_pc = 32'h3010; cyc(1'b1, 1'b0, 1'b1, 32'h4003, 1'b0, 1'b0, 4'h0);
      // exception beats rfi and branch
      m_pc = 32'h3020; cyc(1'b1, 1'b0, 1'b1, 32'h5000, 1'b1, 1'b1, 4'h3);
      repeat (3) idle(1'b0);
      // branch under stall held in PEND
      m_pc = 32'h3010; cyc(1'b1, 1'b1, 1'b1, 32'h5000, 1'b0, 1'b0, 4'h0);
      idle(1'b1); idle(1'b1); idle(1'b0); idle(1'b0);
      // exception overrides held branch, later rfi returns to srr0
      m_pc = 32'h3040; cyc(1'b1, 1'b1, 1'b1, 32'h6000, 1'b0, 1'b0, 4'h0);
      cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 4'h1);
      cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 4'h7);
      cyc(1'b1, 1'b1, 1'b1, 32'h7000, 1'b1, 1'b0, 4'h0);
      idle(1'b0); idle(1'b0);
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0);
      idle(1'b0);
      // exception on the release cycle of a held branch
      cyc(1'b1, 1'b1, 1'b1, 32'h8000, 1'b0, 1'b0, 4'h0);
      cyc(1'b1, 1'b0, 1'b1, 32'h9000, 1'b1, 1'b1, 4'h2);
      idle(1'b0); idle(1'b0);
      // reset while a redirect is pending
      cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 4'h5);
      cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0);
      repeat (4) idle(1'b0);
      // random traffic
      for (int i = 0; i < 3000; i++) begin
         r = ($urandom_range(0, 299) != 0);
         s = ($urandom_range(0, 9) < 4);
         b = ($urandom_range(0, 6) == 0);
         f = ($urandom_range(0, 9) == 0);
         e = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 49) == 0)
            m_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom;
         cyc(r, s, b, $urandom, f, e, 4'($urandom_range(0, 15)));
      end
      @(negedge clk);
      @(negedge clk);
      cmp("queue_drained", 32'(q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
